// File: rtl/otter_pipe_pkg.sv
// Shared types for the OTTER pipeline register chain: RV32I opcodes, the NOP word,
// the per-stage payload struct and opcode classification helpers.
package otter_pipe_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned REG_W = 5;
  localparam int unsigned OPC_W = 7;
  localparam int unsigned CNT_W = 32;

  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [XLEN-1:0] RESET_PC  = 32'h0000_0000;

  typedef enum logic [OPC_W-1:0] {
    OPC_LUI    = 7'b0110111,
    OPC_AUIPC  = 7'b0010111,
    OPC_JAL    = 7'b1101111,
    OPC_JALR   = 7'b1100111,
    OPC_BRANCH = 7'b1100011,
    OPC_LOAD   = 7'b0000011,
    OPC_STORE  = 7'b0100011,
    OPC_OP_IMM = 7'b0010011,
    OPC_OP     = 7'b0110011,
    OPC_SYSTEM = 7'b1110011
  } opcode_t;

  typedef struct packed {
    logic [XLEN-1:0] ir;
    logic [XLEN-1:0] pc;
    logic            valid;
  } stage_t;

  function automatic stage_t bubble_at(input logic [XLEN-1:0] pc);
    return '{ir: NOP_INSTR, pc: pc, valid: 1'b0};
  endfunction

  function automatic logic op_writes_rd(input opcode_t op);
    case (op)
      OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR,
      OPC_OP_IMM, OPC_OP, OPC_LOAD: return 1'b1;
      default:                      return 1'b0;
    endcase
  endfunction

  function automatic logic op_uses_rs1(input opcode_t op);
    case (op)
      OPC_JALR, OPC_BRANCH, OPC_LOAD, OPC_STORE,
      OPC_OP_IMM, OPC_OP, OPC_SYSTEM: return 1'b1;
      default:                        return 1'b0;
    endcase
  endfunction

  function automatic logic op_uses_rs2(input opcode_t op);
    case (op)
      OPC_BRANCH, OPC_STORE, OPC_OP: return 1'b1;
      default:                       return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/otter_hazard_detect.sv
// Combinational load-use and decode-branch hazard detector for the OTTER pipeline.
module otter_hazard_detect
  import otter_pipe_pkg::*;
(
  input  logic [XLEN-1:0] DEC_IR,
  input  logic            DEC_VALID,
  input  logic [XLEN-1:0] EXE_IR,
  input  logic            EXE_VALID,
  input  logic [XLEN-1:0] MEM_IR,
  input  logic            MEM_VALID,
  output logic            STALL
);

  opcode_t           dec_op, exe_op, mem_op;
  logic [REG_W-1:0]  dec_rs1, dec_rs2, exe_rd, mem_rd;
  logic              use_rs1, use_rs2, dec_is_br;
  logic              exe_wr, mem_wr, exe_hit, mem_hit;
  logic              unused_ir_bits;

  assign dec_op  = opcode_t'(DEC_IR[6:0]);
  assign exe_op  = opcode_t'(EXE_IR[6:0]);
  assign mem_op  = opcode_t'(MEM_IR[6:0]);
  assign dec_rs1 = DEC_IR[19:15];
  assign dec_rs2 = DEC_IR[24:20];
  assign exe_rd  = EXE_IR[11:7];
  assign mem_rd  = MEM_IR[11:7];

  assign unused_ir_bits = ^{DEC_IR[31:25], DEC_IR[14:7],
                            EXE_IR[31:12], MEM_IR[31:12]};

  assign use_rs1   = op_uses_rs1(dec_op);
  assign use_rs2   = op_uses_rs2(dec_op);
  assign dec_is_br = (dec_op == OPC_BRANCH) || (dec_op == OPC_JALR);

  // x0 is never a producer, so a zero rd can never create a dependency
  assign exe_wr = EXE_VALID && op_writes_rd(exe_op) && (exe_rd != '0);
  assign mem_wr = MEM_VALID && op_writes_rd(mem_op) && (mem_rd != '0);

  assign exe_hit = exe_wr && ((use_rs1 && (exe_rd == dec_rs1)) ||
                              (use_rs2 && (exe_rd == dec_rs2)));
  assign mem_hit = mem_wr && ((use_rs1 && (mem_rd == dec_rs1)) ||
                              (use_rs2 && (mem_rd == dec_rs2)));

  // Branches resolve in DEC, so they cannot wait for EXE/MEM forwarding
  assign STALL = DEC_VALID && ((exe_hit && (exe_op == OPC_LOAD)) ||
                               (dec_is_br && exe_hit) ||
                               (dec_is_br && mem_hit && (mem_op == OPC_LOAD)));

endmodule

// File: rtl/otter_pipe_regs.sv
// OTTER DEC/EXE/MEM/WB pipeline registers with hazard bubbles, redirect squash and freeze.
// Optional stall/flush event counters are built when PIPE_PERF_CNT_EN is defined.
module otter_pipe_regs
  import otter_pipe_pkg::*;
(
  input  logic            CLK,
  input  logic            RST,
  input  logic [XLEN-1:0] IF_IR,
  input  logic [XLEN-1:0] IF_PC,
  input  logic            CLEAR,
  input  logic            HOLD,
  output logic            PC_WRITE,
  output logic            STALL,
  output logic [XLEN-1:0] DEC_IR,
  output logic [XLEN-1:0] EXE_IR,
  output logic [XLEN-1:0] MEM_IR,
  output logic [XLEN-1:0] WB_IR,
  output logic [XLEN-1:0] DEC_PC,
  output logic [XLEN-1:0] EXE_PC,
  output logic [XLEN-1:0] MEM_PC,
  output logic [XLEN-1:0] WB_PC,
  output logic            DEC_VALID,
  output logic            EXE_VALID,
  output logic            MEM_VALID,
  output logic            WB_VALID
`ifdef PIPE_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] STALL_CNT,
  output logic [CNT_W-1:0] FLUSH_CNT
`endif
);

  localparam stage_t RESET_STAGE = '{ir: NOP_INSTR, pc: RESET_PC, valid: 1'b0};

  stage_t dec_q, exe_q, mem_q, wb_q;
  stage_t dec_d, exe_d, mem_d, wb_d;
  logic   stall_c;

  otter_hazard_detect u_hazard (
    .DEC_IR    (dec_q.ir),
    .DEC_VALID (dec_q.valid),
    .EXE_IR    (exe_q.ir),
    .EXE_VALID (exe_q.valid),
    .MEM_IR    (mem_q.ir),
    .MEM_VALID (mem_q.valid),
    .STALL     (stall_c)
  );

  // Priority: HOLD freezes all, STALL holds DEC and bubbles EXE, CLEAR squashes fetch
  always_comb begin
    dec_d = dec_q;
    exe_d = exe_q;
    mem_d = mem_q;
    wb_d  = wb_q;
    if (!HOLD) begin
      wb_d  = mem_q;
      mem_d = exe_q;
      if (stall_c) begin
        exe_d = bubble_at(dec_q.pc);
      end else begin
        exe_d = dec_q;
        dec_d = CLEAR ? bubble_at(IF_PC)
                      : '{ir: IF_IR, pc: IF_PC, valid: 1'b1};
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      dec_q <= RESET_STAGE;
      exe_q <= RESET_STAGE;
      mem_q <= RESET_STAGE;
      wb_q  <= RESET_STAGE;
    end else begin
      dec_q <= dec_d;
      exe_q <= exe_d;
      mem_q <= mem_d;
      wb_q  <= wb_d;
    end
  end

`ifdef PIPE_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  // Counters follow the same priority as the stage registers
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (!HOLD) begin
      if (stall_c) begin
        stall_cnt_d = stall_cnt_q + CNT_W'(1);
      end else if (CLEAR) begin
        flush_cnt_d = flush_cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign STALL_CNT = stall_cnt_q;
  assign FLUSH_CNT = flush_cnt_q;
`endif

  assign STALL    = stall_c;
  assign PC_WRITE = !HOLD && !stall_c;

  assign DEC_IR    = dec_q.ir;
  assign EXE_IR    = exe_q.ir;
  assign MEM_IR    = mem_q.ir;
  assign WB_IR     = wb_q.ir;
  assign DEC_PC    = dec_q.pc;
  assign EXE_PC    = exe_q.pc;
  assign MEM_PC    = mem_q.pc;
  assign WB_PC     = wb_q.pc;
  assign DEC_VALID = dec_q.valid;
  assign EXE_VALID = exe_q.valid;
  assign MEM_VALID = mem_q.valid;
  assign WB_VALID  = wb_q.valid;

endmodule

// File: doc/otter_pipe_regs.md
# otter_pipe_regs

Pipeline register chain for the OTTER pipelined RV32I core. It carries each instruction word and its PC from fetch through the decode, execute, memory and writeback stages. It also supplies the four per-stage instruction registers that the stage decoders read. It detects load-use and decode-branch data hazards, inserts bubbles, squashes the wrong-path fetch on redirects, and tells fetch when the PC may advance.

## Interface
- NOP_INSTR, 32'h00000013 (addi x0,x0,0), instruction word used for reset contents and bubbles
- RESET_PC, 32'h00000000, PC value loaded into every stage on reset
- CLK  in  1  single clock, all state updates on rising edge
- RST  in  1  asynchronous, active-high reset
- IF_IR  in  32  instruction word returned by fetch this cycle
- IF_PC  in  32  PC of IF_IR
- CLEAR  in  1  redirect (taken branch, JAL, JALR, trap) decided by the instruction currently in DEC
- HOLD  in  1  global freeze (memory wait); no stage changes
- PC_WRITE  out  1  fetch may advance PC this cycle
- STALL  out  1  hazard stall active this cycle
- DEC_IR, EXE_IR, MEM_IR, WB_IR  out  32 each  stage instruction words (decoder inputs)
- DEC_PC, EXE_PC, MEM_PC, WB_PC  out  32 each  stage PCs
- DEC_VALID, EXE_VALID, MEM_VALID, WB_VALID  out  1 each  stage holds a real (non-bubble) instruction
- STALL_CNT, FLUSH_CNT  out  32 each  present only with PIPE_PERF_CNT_EN

## Operation
- Reset (async, RST=1):
  - all *_IR = NOP_INSTR, all *_PC = RESET_PC, all *_VALID = 0, counters = 0.
- Per rising edge, apply the first matching rule in this priority order:
  - HOLD=1: every stage register and counter keeps its value. STALL/CLEAR have no effect.
  - STALL=1: DEC keeps its value. EXE loads the bubble (NOP_INSTR, VALID=0, PC=DEC_PC). MEM←EXE, WB←MEM. CLEAR is ignored, because a DEC branch evaluated on stale operands is not trusted. STALL_CNT increments.
  - CLEAR=1: DEC loads the bubble (NOP_INSTR, VALID=0, PC=IF_PC). EXE←DEC, MEM←EXE, WB←MEM. FLUSH_CNT increments.
  - Otherwise: DEC←{IF_IR,IF_PC,1}, EXE←DEC, MEM←EXE, WB←MEM.
- PC_WRITE = !HOLD && !STALL (combinational).
- Hazard detection is combinational on the registered DEC/EXE/MEM IRs.
  - rd = IR[11:7], rs1 = IR[19:15], rs2 = IR[24:20].
  - A stage writes rd when it is VALID, its opcode is in {LUI, AUIPC, JAL, JALR, OP_IMM, OP, LOAD}, and rd≠0.
  - DEC uses rs1 when its opcode is in {JALR, BRANCH, LOAD, STORE, OP_IMM, OP, SYSTEM}.
  - DEC uses rs2 when its opcode is in {BRANCH, STORE, OP}.
  - STALL=1 when DEC_VALID and any of the following holds:
    - (a) EXE is LOAD, writes rd, and rd matches a used DEC source;
    - (b) DEC is BRANCH or JALR, and EXE writes an rd that matches a used source;
    - (c) DEC is BRANCH or JALR, MEM is LOAD, and its rd matches a used source.
- Consequences: load→use costs 1 bubble; ALU→branch costs 1 bubble; load→branch costs 2 bubbles.
- Unknown opcodes use no sources and write nothing.
- Counters wrap modulo 2^32.

## Timing
- All stage outputs are registered. The latency from IF_IR to DEC_IR is 1 cycle, and each further stage adds 1 cycle; IF→WB is 4 cycles with no stalls.
- STALL and PC_WRITE are valid in the same cycle as the IRs that cause them. There is no registered delay.
- When CLEAR is high in cycle n, the fetch word presented in cycle n never reaches DEC_VALID=1.
- The redirect target fetched in cycle n+1 enters DEC at edge n+2.
- Releasing HOLD resumes exactly from the frozen state. Hazard evaluation during HOLD is still visible on STALL but is not acted upon.
- RST asserted mid-operation clears all in-flight instructions immediately (asynchronously). The first edge after RST deasserts loads IF_IR normally.

## Configuration
- PIPE_PERF_CNT_EN defined: STALL_CNT and FLUSH_CNT ports and registers exist and behave as above.
- Undefined: the ports and registers are absent, and the block behaviour is otherwise identical.

## Structure
- Shared package otter_pipe_pkg:
  - opcode_t enum (LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP_IMM, OP, SYSTEM with their RV32I encodings);
  - a NOP constant;
  - a stage struct {ir, pc, valid}.
  - The stage decoders import the same opcode_t.
- One combinational sub-module, otter_hazard_detect. Inputs: DEC/EXE/MEM IR and valid. Output: STALL.

## Test plan
- Reset then 6 straight-line ADDIs, no hazards → each appears in WB exactly 4 cycles after IF, STALL never 1, PC_WRITE=1 throughout.
- `lw x5,0(x1)` followed by `add x6,x5,x2` → STALL=1 for exactly 1 cycle, one bubble (EXE_VALID=0, EXE_IR=32'h00000013), add reaches EXE one cycle late; STALL_CNT=1.
- `lw x5` followed by `beq x5,x0` → 2 consecutive stall cycles, and CLEAR asserted during both is ignored (DEC_IR still the beq afterwards).
- `beq` in DEC with CLEAR=1, IF_IR=32'hDEADBEEF → next DEC_VALID=0 and DEC_IR=NOP, beq in EXE; FLUSH_CNT=1.
- HOLD=1 for 3 cycles mid-stream with a pending load-use hazard → all outputs constant, counters constant; after release, exactly 1 bubble inserted.
- RST pulsed asynchronously between edges with 4 valid instructions in flight → all VALID=0, IR=NOP, PC=RESET_PC immediately, before the next edge.
